execute_muldiv_unit: RTL and testbench
======================================

// Module: execute_muldiv_unit
// PURPOSE
//  Execute-stage consumer of the D/X pipeline register outputs: an iterative unsigned
//  multiply/divide unit. Takes the two buffered register operands and computes MUL, MULH,
//  DIVU or REMU at one bit per cycle. Drives a stall back to the D/X register and fetch
//  while busy. Presents a one-cycle done pulse with a held result to the X/M register.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count per operation
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request new op this cycle (qualified by op, operands)
//  op         in   2      00 MUL low, 01 MULH high (unsigned), 10 DIVU, 11 REMU
//  operand_a  in   WIDTH  multiplicand / dividend (read_data_buffered_0)
//  operand_b  in   WIDTH  multiplier / divisor (read_data_buffered_1)
//  flush      in   1      abort in-flight op (branch mispredict/exception)
//  busy       out  1      op in progress (state MUL or DIV)
//  stall      out  1      hold upstream pipeline registers
//  done       out  1      one-cycle pulse: result valid
//  result     out  WIDTH  selected result, held until next accepted start
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, counter=0, internal accumulators=0.
//  Reset at any point, including mid-op, returns all outputs to 0 on the next edge.
//  States:
//   IDLE  start&!flush -> MUL (op[1]=0) or DIV (op[1]=1); latch op and operands.
//   MUL   shift-add, one multiplier bit per edge, counter WIDTH-1..0.
//         counter==0 at edge -> DONE.
//   DIV   restoring division, one quotient bit per edge. Same counter rule -> DONE.
//   DONE  done=1 for exactly this cycle. Behaves as IDLE for start/flush;
//         with no start it returns to IDLE.
//  Start rules:
//   Start is accepted only in IDLE or DONE. Start in MUL/DIV is ignored; it is not queued.
//  Latency:
//   Start sampled at edge E0 -> WIDTH iteration edges E1..E_WIDTH.
//   done=1 and result valid in the cycle following E_WIDTH.
//   Fixed latency for all ops and operand values; no early-out.
//  Output decode:
//   busy  = (state==MUL)|(state==DIV).
//   stall = busy | (start & (state==IDLE|state==DONE) & !flush); combinational.
//  Arithmetic:
//   2*WIDTH-bit product register; MUL = product[WIDTH-1:0], MULH = product[2W-1:W].
//   DIVU = quotient, REMU = remainder; all unsigned; no overflow flag.
//   Divide by zero: natural restoring outcome, quotient all ones, remainder=operand_a.
//   Same latency as any other op.
//  Result register: updated only at the DONE transition; stable otherwise.
//   Not modified by flush.
//  Flush:
//   Any state -> IDLE on the next edge; counter cleared; done not asserted.
//   flush and start in the same cycle: flush wins; start is dropped.
//  Operand capture:
//   operand_a/operand_b are sampled only at the accepting edge.
//   Later changes to them do not affect the op.
// TESTING (WIDTH=32)
//  1. MUL 7 x 6: start 1 cycle -> stall=1 same cycle; done at cycle 33; result=0x0000002A.
//  2. MULH 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL of same -> 0x00000001.
//  3. DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; both done at cycle 33.
//  4. DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234; latency unchanged.
//  5. Flush at cycle 10 of a MUL -> busy=0 next cycle; done never pulses; result keeps prior value.
//  6. Start at cycle 5 of a DIV -> ignored, done at 33 with the original result.
//     Reset at cycle 20 -> all outputs 0 next cycle.
//     Back-to-back start in the DONE cycle -> accepted.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// One product or quotient bit per cycle, with a fixed latency of WIDTH iterations.
module execute_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Upper half: partial product / remainder; lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sel_hi_q, sel_hi_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  assign accept = start & ~flush & ((state_q == StIdle) | (state_q == StDone));
  assign busy   = (state_q == StMul) | (state_q == StDiv);
  assign stall  = busy | accept;
  assign done   = (state_q == StDone);
  assign result = result_q;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sel_hi_d = sel_hi_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d  = op[1] ? StDiv : StMul;
          cnt_d    = CntW'(WIDTH - 1);
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? operand_a : operand_b)};
          opnd_d   = op[1] ? operand_b : operand_a;
          sel_hi_d = op[0];
        end
      end
      StMul: acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      StDiv: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (div_diff[WIDTH]) begin
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
      end
    endcase

    if (busy) begin
      if (cnt_q == '0) begin
        state_d  = StDone;
        result_d = sel_hi_d ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sel_hi_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sel_hi_q <= sel_hi_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed cases plus randomized traffic
// compared each cycle against an arithmetic reference model.
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit check_en = 1'b0;

  // Reference model: cycles left in the op, pending/visible result, done pulse.
  int          m_rem = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;

  execute_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_rem = 0;
        m_done = 1'b0;
        m_result = '0;
      end else begin
        m_done = 1'b0;
        if (flush) begin
          m_rem = 0;
        end else if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_done = 1'b1;
            m_result = m_pend;
          end
        end else if (start) begin
          m_rem = 32;
          m_pend = ref_result(op, operand_a, operand_b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("model_busy", 32'(busy), 32'(m_rem > 0));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_stall", 32'(stall), 32'((m_rem > 0) | (start & ~flush)));
        chk("model_result", result, m_result);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(negedge clk);
    chk("stall_on_start", 32'(stall), 32'd1);
    step();
    start = 1'b0;
    op = 2'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    cyc = 1;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp);
    bit found = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else step();
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'd33);
    chk({name, "_result"}, result, exp);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {busy, stall, done, 29'd0}, 32'd0);
    chk("reset_result", result, 32'd0);
    step();

    start_op(2'd0, 32'd7, 32'd6);
    wait_done("mul_7x6", 32'h0000_002A);
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulh_ff", 32'hFFFF_FFFE);
    start_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_ff", 32'h0000_0001);
    start_op(2'd2, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'h0000_000E);
    start_op(2'd3, 32'd100, 32'd7);
    wait_done("remu_100_7", 32'h0000_0002);
    start_op(2'd2, 32'h1234, 32'd0);
    wait_done("divu_by0", 32'hFFFF_FFFF);
    start_op(2'd3, 32'h1234, 32'd0);
    wait_done("remu_by0", 32'h0000_1234);

    // Flush at cycle 10 of a MUL: no done, prior result kept.
    start_op(2'd0, 32'd3, 32'd5);
    while (cyc < 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    begin
      bit saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        step();
      end
      chk("flush_no_done", 32'(saw_done), 32'd0);
    end
    chk("flush_result_kept", result, 32'h0000_1234);

    // Start during DIV is ignored.
    start_op(2'd2, 32'd1000, 32'd10);
    while (cyc < 5) step();
    start = 1'b1;
    op = 2'd0;
    operand_a = 32'd2;
    operand_b = 32'd3;
    step();
    start = 1'b0;
    wait_done("div_ignore_start", 32'h0000_0064);

    // Reset mid-op.
    start_op(2'd0, 32'd11, 32'd13);
    while (cyc < 20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {busy, stall, done, 29'd0}, 32'd0);
    chk("midreset_result", result, 32'd0);
    step();

    // Back-to-back start in the DONE cycle.
    start_op(2'd2, 32'd100, 32'd7);
    while (cyc < 33) step();
    op = 2'd0;
    operand_a = 32'd9;
    operand_b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_first_result", result, 32'h0000_000E);
    step();
    start = 1'b0;
    cyc = 1;
    wait_done("b2b_second", 32'h0000_0051);

    // Randomized traffic, checked every cycle by the model.
    repeat (8000) begin
      reset = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) == 0);
      op = 2'($urandom);
      operand_a = pick();
      operand_b = pick();
      step();
    end
    reset = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
